// File: rtl/hex_digit_sequencer_if.sv
// Bus between the hex digit sequencer and whatever drives or observes it.
// The master side supplies the button and mode controls; the slave side
// (the sequencer) returns the current digit, the segment byte and the wrap flag.
interface hex_digit_sequencer_if;
  logic       step_btn;
  logic       auto_en;
  logic       count_up;
  logic [7:0] sevenseg_out;
  logic [3:0] digit;
  logic       wrap_pulse;

  modport master (
    output step_btn, auto_en, count_up,
    input  sevenseg_out, digit, wrap_pulse
  );

  modport slave (
    input  step_btn, auto_en, count_up,
    output sevenseg_out, digit, wrap_pulse
  );
endinterface

// File: rtl/hex_digit_sequencer.sv
// Hex digit sequencer: holds a 4-bit digit that steps on a free-running tick
// (when auto_en is set) or on a debounced press of step_btn. It drives an
// active-low seven-segment byte, bit0=a .. bit6=g, bit7=dp.
// Optional feature macro: SEVENSEG_DP_BLINK_EN makes the decimal point toggle
// on every tick. Without it, the decimal point stays off.
module hex_digit_sequencer #(
  parameter int TICK_DIV     = 12000000,
  parameter int DEBOUNCE_LEN = 4096
) (
  input logic                  clk,
  input logic                  reset,
  hex_digit_sequencer_if.slave bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_LEN + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_LEN - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          deb_q, deb_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    digit_q, digit_d;
  logic          wrap_q, wrap_d;
  logic [7:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          btn_ev;
  logic          tick;
  logic          step;

  // Two-flop synchroniser for the asynchronous push button
  always_comb begin
    sync1_d = bus.step_btn;
    sync2_d = sync1_q;
  end

  // Debouncer: accept a new level after DEBOUNCE_LEN consecutive differing cycles
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
    btn_ev = deb_d & ~deb_q;
  end

  // Prescaler: tick on the last count; a press restarts the period
  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    presc_d = presc_q + 1'b1;
    if (tick || btn_ev) begin
      presc_d = '0;
    end
  end

  // Digit stepping: a coincident tick and press still give a single step
  always_comb begin
    step    = btn_ev | (tick & bus.auto_en);
    digit_d = digit_q;
    wrap_d  = 1'b0;
    if (step) begin
      if (bus.count_up) begin
        digit_d = digit_q + 4'd1;
        wrap_d  = (digit_q == 4'hF);
      end else begin
        digit_d = digit_q - 4'd1;
        wrap_d  = (digit_q == 4'h0);
      end
    end
  end

`ifdef SEVENSEG_DP_BLINK_EN
  // Decimal point blinks on every tick regardless of auto_en
  always_comb begin
    dp_d = tick ? ~dp_q : dp_q;
  end
`else
  // Decimal point held off
  always_comb begin
    dp_d = 1'b1;
  end
`endif

  // Segment decode from the registered digit, so the byte lags digit by one cycle
  always_comb begin
    seg_d = 8'hC0;
    unique case (digit_q)
      4'h0: seg_d[6:0] = 7'h40;
      4'h1: seg_d[6:0] = 7'h79;
      4'h2: seg_d[6:0] = 7'h24;
      4'h3: seg_d[6:0] = 7'h30;
      4'h4: seg_d[6:0] = 7'h19;
      4'h5: seg_d[6:0] = 7'h12;
      4'h6: seg_d[6:0] = 7'h02;
      4'h7: seg_d[6:0] = 7'h78;
      4'h8: seg_d[6:0] = 7'h00;
      4'h9: seg_d[6:0] = 7'h10;
      4'hA: seg_d[6:0] = 7'h08;
      4'hB: seg_d[6:0] = 7'h03;
      4'hC: seg_d[6:0] = 7'h46;
      4'hD: seg_d[6:0] = 7'h21;
      4'hE: seg_d[6:0] = 7'h06;
      4'hF: seg_d[6:0] = 7'h0E;
      default: seg_d[6:0] = 7'h40;
    endcase
    seg_d[7] = dp_q;
  end

  // State registers with synchronous reset; reset drops any pending step
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_q     <= 1'b0;
      deb_cnt_q <= '0;
      presc_q   <= '0;
      digit_q   <= 4'h0;
      wrap_q    <= 1'b0;
      seg_q     <= 8'hC0;
      dp_q      <= 1'b1;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
      presc_q   <= presc_d;
      digit_q   <= digit_d;
      wrap_q    <= wrap_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign bus.digit        = digit_q;
  assign bus.wrap_pulse   = wrap_q;
  assign bus.sevenseg_out = seg_q;

endmodule
